// File: rtl/mem_be_ctrl_if.sv
// Request/response bus for mem_be_ctrl: one request channel
// (valid/ready handshake) and one strobed response channel.
interface mem_be_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 24
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                    valid;
  logic                    ready;
  logic                    wr_rd;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [WIDTH-1:0]        wdata;
  logic [WIDTH/8-1:0]      be;
  logic [WIDTH-1:0]        rdata;
  logic                    rvalid;
  logic                    err;
  logic                    parity_err;

  modport master (
    output valid, wr_rd, addr, wdata, be,
    input  ready, rdata, rvalid, err, parity_err
  );

  modport slave (
    input  valid, wr_rd, addr, wdata, be,
    output ready, rdata, rvalid, err, parity_err
  );
endinterface

// File: rtl/mem_be_ctrl.sv
// mem_be_ctrl: single-port word memory with byte-enable writes and a
// fixed-latency read path.
//  - Writes complete in IDLE at the accepting edge, one per cycle.
//  - Reads park the FSM in RD_WAIT for RD_LAT cycles; the response
//    (rvalid/rdata/err/parity_err) is a registered one-cycle strobe.
//  - Addresses >= DEPTH never touch memory and raise a one-cycle err.
//  - Reset clears the whole array, so contents are known after release.
// Optional feature: define MEM_PARITY_EN to store one even-parity bit
// per byte and flag mismatches on the read response (parity_err).
module mem_be_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 24,
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_be_ctrl_if.slave bus
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int NB         = WIDTH / 8;
  localparam int CNT_W      = 3;

  // One extra bit so the compare also works when DEPTH is a power of two.
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  // Counter runs RD_LAT-1 .. 0 while in RD_WAIT; response fires at 0.
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(RD_LAT - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;

  logic [WIDTH-1:0]      mem_r [DEPTH];

  logic                  rvalid_r;
  logic                  err_r;
  logic                  parity_err_r;
  logic [WIDTH-1:0]      rdata_r;

  logic                  accept_s;
  logic                  req_in_range_s;
  logic                  rd_in_range_s;
  logic                  wr_fire_s;
  logic                  wr_oor_s;
  logic                  rd_start_s;
  logic                  rd_done_s;
  logic [WIDTH-1:0]      rd_word_s;
  logic                  rd_perr_s;

  // Request decode: a request is taken only while the FSM sits in IDLE.
  assign bus.ready      = (state_r == IDLE);
  assign accept_s       = bus.valid && (state_r == IDLE);
  assign req_in_range_s = ({1'b0, bus.addr} < DEPTH_L);
  assign rd_in_range_s  = ({1'b0, addr_r} < DEPTH_L);
  assign wr_fire_s      = accept_s && bus.wr_rd && req_in_range_s;
  assign wr_oor_s       = accept_s && bus.wr_rd && !req_in_range_s;
  assign rd_start_s     = accept_s && !bus.wr_rd;
  assign rd_done_s      = (state_r == RD_WAIT) && (cnt_r == {CNT_W{1'b0}});

  // Registered response strobes drive the bus directly.
  assign bus.rvalid     = rvalid_r;
  assign bus.rdata      = rdata_r;
  assign bus.err        = err_r;
  assign bus.parity_err = parity_err_r;

  // Next-state and latency-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (rd_start_s) begin
          state_nxt_s = RD_WAIT;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      end
      RD_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = RD_WAIT;
          cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state, latency counter and captured read address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (rd_start_s) begin
        addr_r <= bus.addr;
      end
    end
  end

  // Data array: cleared on reset, byte-merged on in-range writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_fire_s) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.be[k]) begin
          mem_r[bus.addr][8*k +: 8] <= bus.wdata[8*k +: 8];
        end
      end
    end
  end

  // Read word at the response edge; out-of-range reads return zero.
  always_comb begin
    rd_word_s = {WIDTH{1'b0}};
    if (rd_in_range_s) begin
      rd_word_s = mem_r[addr_r];
    end else begin
      rd_word_s = {WIDTH{1'b0}};
    end
  end

`ifdef MEM_PARITY_EN
  // Even parity per byte: the stored bit equals the XOR of its byte.
  function automatic logic [NB-1:0] byte_parity(input logic [WIDTH-1:0] d);
    logic [NB-1:0] p;
    p = {NB{1'b0}};
    for (int k = 0; k < NB; k++) begin
      p[k] = ^d[8*k +: 8];
    end
    return p;
  endfunction

  logic [DEPTH-1:0][NB-1:0] par_mem_r;
  logic [NB-1:0]            wr_par_s;

  assign wr_par_s = byte_parity(bus.wdata);

  // Parity array: each bit is written together with its byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_mem_r <= {(DEPTH*NB){1'b0}};
    end else if (wr_fire_s) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.be[k]) begin
          par_mem_r[bus.addr][k] <= wr_par_s[k];
        end
      end
    end
  end

  // Recompute parity of the read word and compare with the stored bits.
  always_comb begin
    rd_perr_s = 1'b0;
    if (rd_in_range_s) begin
      rd_perr_s = (byte_parity(rd_word_s) != par_mem_r[addr_r]);
    end else begin
      rd_perr_s = 1'b0;
    end
  end
`else
  assign rd_perr_s = 1'b0;
`endif

  // Response strobes: each is high for exactly one cycle, rdata is zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_r     <= 1'b0;
      rdata_r      <= {WIDTH{1'b0}};
      err_r        <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      rvalid_r     <= rd_done_s;
      rdata_r      <= rd_done_s ? rd_word_s : {WIDTH{1'b0}};
      err_r        <= wr_oor_s || (rd_done_s && !rd_in_range_s);
      parity_err_r <= rd_done_s && rd_perr_s;
    end
  end

endmodule

// File: tb/tb_mem_be_ctrl.sv
// Scoreboard bench for mem_be_ctrl (WIDTH=16, DEPTH=24, RD_LAT=2).
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_mem_be_ctrl;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 24;
  localparam int RD_LAT = 2;

  typedef struct {
    logic        rv;
    logic [15:0] rd;
    logic        er;
    logic        pe;
    int          acc;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   last_acc;
  exp_t q[$];
  exp_t e;

  mem_be_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mem_be_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per response strobe.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.rvalid || bus.err) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: rvalid=%0b err=%0b, expected no strobe", bus.rvalid, bus.err);
        end else begin
          e = q.pop_front();
          check("rvalid", bus.rvalid, e.rv);
          check("rdata", bus.rdata, e.rd);
          check("err", bus.err, e.er);
          check("parity_err", bus.parity_err, e.pe);
          check("latency", cyc - e.acc, e.lat);
        end
      end else begin
        check("rdata_idle", bus.rdata, 16'h0000);
      end
    end
  end

  // Drive one request at a negedge once ready is seen; returns just after the accepting edge.
  task automatic send(input logic w, input logic [4:0] a, input logic [15:0] d, input logic [1:0] b);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!bus.ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: ready=0 after %0d cycles, expected 1", g);
    end
    bus.valid = 1'b1;
    bus.wr_rd = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.be    = b;
    last_acc  = cyc + 1;
    @(posedge clk);
    #1 bus.valid = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] b);
    exp_t x;
    send(1'b1, a, d, b);
    if (a >= 5'd24) begin
      x = '{rv: 1'b0, rd: 16'h0000, er: 1'b1, pe: 1'b0, acc: last_acc, lat: 0};
      q.push_back(x);
    end
  endtask

  // Read with expected data; checks ready stays low while waiting.
  // With noise=1, a write is driven on the bus while ready is low.
  task automatic rd(input logic [4:0] a, input logic [15:0] d, input logic er, input logic pe, input logic noise);
    exp_t x;
    send(1'b0, a, 16'h0000, 2'b00);
    x = '{rv: 1'b1, rd: d, er: er, pe: pe, acc: last_acc, lat: RD_LAT};
    q.push_back(x);
    for (int i = 1; i <= RD_LAT; i++) begin
      @(negedge clk);
      check("ready_low_in_rd_wait", bus.ready, 1'b0);
      if (noise && i < RD_LAT) begin
        bus.valid = 1'b1;
        bus.wr_rd = 1'b1;
        bus.addr  = 5'd9;
        bus.wdata = 16'hFFFF;
        bus.be    = 2'b11;
      end else begin
        bus.valid = 1'b0;
      end
    end
  endtask

  initial begin
    int first_acc;
    int g;
    rst       = 1'b0;
    cyc       = 0;
    vectors   = 0;
    miscompares = 0;
    last_acc  = 0;
    bus.valid = 1'b0;
    bus.wr_rd = 1'b0;
    bus.addr  = 5'd0;
    bus.wdata = 16'h0000;
    bus.be    = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_ready", bus.ready, 1'b1);
    check("reset_rvalid", bus.rvalid, 1'b0);
    check("reset_err", bus.err, 1'b0);
    check("reset_parity_err", bus.parity_err, 1'b0);
    check("reset_rdata", bus.rdata, 16'h0000);

    // Full-word write then read; ready-low window checked in rd().
    wr(5'd5, 16'hA5C3, 2'b11);
    rd(5'd5, 16'hA5C3, 1'b0, 1'b0, 1'b0);

    // be=0 write leaves memory unchanged, no err.
    wr(5'd5, 16'hDEAD, 2'b00);
    rd(5'd5, 16'hA5C3, 1'b0, 1'b0, 1'b0);

    // Partial byte writes.
    wr(5'd7, 16'h1234, 2'b11);
    wr(5'd7, 16'hFFFF, 2'b01);
    rd(5'd7, 16'h12FF, 1'b0, 1'b0, 1'b0);
    wr(5'd7, 16'hAB55, 2'b10);
    rd(5'd7, 16'hABFF, 1'b0, 1'b0, 1'b0);

    // Read on the edge right after a write sees the new data.
    wr(5'd11, 16'hCAFE, 2'b11);
    rd(5'd11, 16'hCAFE, 1'b0, 1'b0, 1'b0);

    // Back-to-back: rvalid-cycle acceptance of the next read.
    rd(5'd5, 16'hA5C3, 1'b0, 1'b0, 1'b0);
    rd(5'd11, 16'hCAFE, 1'b0, 1'b0, 1'b0);

    // Fill 0..23 with addr*3, one write per cycle.
    wr(5'd0, 16'd0, 2'b11);
    first_acc = last_acc;
    for (int i = 1; i < 24; i++) begin
      wr(5'(i), 16'(i * 3), 2'b11);
    end
    check("b2b_write_cycles", last_acc - first_acc, 23);
    for (int i = 0; i < 24; i++) begin
      rd(5'(i), 16'(i * 3), 1'b0, 1'b0, 1'b0);
    end

    // Requests while ready=0 are ignored.
    rd(5'd9, 16'd27, 1'b0, 1'b0, 1'b1);
    rd(5'd9, 16'd27, 1'b0, 1'b0, 1'b0);

    // Out-of-range write and read.
    wr(5'd30, 16'hBEEF, 2'b11);
    rd(5'd30, 16'h0000, 1'b1, 1'b0, 1'b0);
    rd(5'd6, 16'd18, 1'b0, 1'b0, 1'b0);
    rd(5'd23, 16'd69, 1'b0, 1'b0, 1'b0);

    // Reset with a read in flight: discarded, memory cleared.
    wr(5'd3, 16'h7777, 2'b11);
    send(1'b0, 5'd3, 16'h0000, 2'b00);
    @(negedge clk);
    check("inflight_ready_low", bus.ready, 1'b0);
    rst = 1'b0;
    #1;
    check("async_reset_ready", bus.ready, 1'b1);
    check("async_reset_rvalid", bus.rvalid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_ready", bus.ready, 1'b1);
    rd(5'd3, 16'h0000, 1'b0, 1'b0, 1'b0);
    rd(5'd5, 16'h0000, 1'b0, 1'b0, 1'b0);
    rd(5'd23, 16'h0000, 1'b0, 1'b0, 1'b0);

`ifdef MEM_PARITY_EN
    // Corrupt the stored low-byte parity bit of word 2.
    wr(5'd2, 16'h00FF, 2'b11);
    rd(5'd2, 16'h00FF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    force dut.par_mem_r[2][0] = 1'b1;
    rd(5'd2, 16'h00FF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    release dut.par_mem_r[2][0];
`else
    wr(5'd2, 16'h00FF, 2'b11);
    rd(5'd2, 16'h00FF, 1'b0, 1'b0, 1'b0);
`endif

    // Drain the scoreboard within a bounded window.
    g = 0;
    while (q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_be_ctrl.md
MEM_BE_CTRL -- requirements
Module: mem_be_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits, multiple of 8, 8..64.
REQ-002 SHALL have parameter DEPTH, default 24, number of words; need not be a power of two.
REQ-003 SHALL have parameter RD_LAT, default 2, read latency in cycles, legal range 1..4.
REQ-004 SHALL have derived parameter ADDR_WIDTH = $clog2(DEPTH), local, not overridable.
REQ-005 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have valid  input  1  request present.
REQ-008 SHALL have ready  output  1  request accepted this edge when valid&&ready.
REQ-009 SHALL have wr_rd  input  1  1=write, 0=read.
REQ-010 SHALL have addr  input  ADDR_WIDTH  word address.
REQ-011 SHALL have wdata  input  WIDTH  write data.
REQ-012 SHALL have be  input  WIDTH/8  byte enables, bit k selects wdata[8k+7:8k].
REQ-013 SHALL have rdata  output  WIDTH  read data, meaningful only while rvalid=1.
REQ-014 SHALL have rvalid  output  1  one-cycle read-response strobe.
REQ-015 SHALL have err  output  1  one-cycle strobe: out-of-range access.
REQ-016 SHALL have parity_err  output  1  one-cycle strobe with rvalid on parity mismatch.

Function
REQ-017 SHALL implement states IDLE and RD_WAIT; ready=1 in IDLE, 0 in RD_WAIT.
REQ-018 Write accepted in IDLE SHALL update only enabled bytes of mem[addr] at the accepting edge; FSM stays IDLE, so back-to-back writes run one per cycle.
REQ-019 Write with be=0 SHALL leave memory unchanged and raise no err.
REQ-020 Read accepted in IDLE SHALL capture addr, enter RD_WAIT, load a latency counter, and drive rvalid=1 with rdata exactly RD_LAT cycles after the accepting edge.
REQ-021 In the rvalid cycle FSM SHALL return to IDLE (ready=1), so the next request is accepted at that same edge.
REQ-022 Read data SHALL reflect all writes accepted on earlier edges (write at edge N, read accepted at N+1 returns new data).
REQ-023 Access with addr>=DEPTH SHALL not modify memory; write: err=1 for the cycle after acceptance; read: rvalid=1, rdata=0, err=1 in the response cycle.
REQ-024 valid, wr_rd, addr, wdata, be SHALL be ignored while ready=0.
REQ-025 rdata SHALL be 0 whenever rvalid=0.

Reset
REQ-026 rst=0 SHALL immediately force FSM to IDLE, counter to 0, rvalid/err/parity_err/rdata to 0, ready to 1 once released.
REQ-027 rst=0 SHALL clear every memory word (and parity bits) to 0.
REQ-028 Read in flight at reset SHALL be discarded; no rvalid after release.

Configuration
REQ-029 With macro MEM_PARITY_EN defined, SHALL store one even-parity bit per byte, write it with its byte, check it on read, and assert parity_err with rvalid on any mismatch.
REQ-030 Without MEM_PARITY_EN, SHALL store no parity bits and tie parity_err to 0; all other behaviour identical.

Verification (WIDTH=16, DEPTH=24, RD_LAT=2)
REQ-031 Write addr=5 wdata=16'hA5C3 be=2'b11, read addr=5 -> rvalid exactly 2 cycles after read accept, rdata=16'hA5C3, ready low for 2 cycles.
REQ-032 Write addr=7 16'h1234 be=11, then 16'hFFFF be=01, read 7 -> rdata=16'h12FF.
REQ-033 Write 0..23 back-to-back with data=addr*3, read 0..23 -> 24 writes in 24 cycles, each read returns addr*3.
REQ-034 Write addr=30 16'hBEEF, read addr=30 -> write err pulse, no memory change; read rvalid with rdata=0 and err=1.
REQ-035 Read addr=3 accepted, rst=0 one cycle later -> no rvalid, ready=1 after release, read of 3 returns 0.
REQ-036 MEM_PARITY_EN: write addr=2 16'h00FF, force stored low-byte parity bit inverted, read 2 -> rvalid with parity_err=1; without macro parity_err stays 0.
